// File: rtl/bin_bbox_detect_if.sv
// Binary video stream bundle: frame/line sync, pixel valid, 1-bit pixel.
// Driven by the stream producer (master), observed by the consumer (slave).
interface bin_bbox_detect_if;
  logic vsync;
  logic hsync;
  logic valid;
  logic data;

  modport master (
    output vsync,
    output hsync,
    output valid,
    output data
  );

  modport slave (
    input vsync,
    input hsync,
    input valid,
    input data
  );
endinterface

// File: rtl/bin_bbox_detect.sv
// Per-frame bounding box and foreground count of a binary stream,
// with the stream forwarded inline after a fixed 1-cycle delay.
module bin_bbox_detect #(
  parameter int X_WIDTH   = 11,
  parameter int Y_WIDTH   = 11,
  parameter int CNT_WIDTH = 20,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  bin_bbox_detect_if.slave     pre_img,
  bin_bbox_detect_if.master    post_img,
  output logic                 bbox_valid,
  output logic                 bbox_found,
  output logic [X_WIDTH-1:0]   bbox_xmin,
  output logic [X_WIDTH-1:0]   bbox_xmax,
  output logic [Y_WIDTH-1:0]   bbox_ymin,
  output logic [Y_WIDTH-1:0]   bbox_ymax,
  output logic [CNT_WIDTH-1:0] fg_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [X_WIDTH-1:0]   X_MAX = '1;
  localparam logic [Y_WIDTH-1:0]   Y_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

  state_t               state;
  logic                 vsync_d;
  logic                 valid_d;
  logic [X_WIDTH-1:0]   x;
  logic [Y_WIDTH-1:0]   y;

  logic                 hit;
  logic [X_WIDTH-1:0]   acc_xmin;
  logic [X_WIDTH-1:0]   acc_xmax;
  logic [Y_WIDTH-1:0]   acc_ymin;
  logic [Y_WIDTH-1:0]   acc_ymax;
  logic [CNT_WIDTH-1:0] acc_cnt;

  logic                 fe;
  logic                 fall;
  logic                 fg;
  logic [X_WIDTH-1:0]   px_x;
  logic [Y_WIDTH-1:0]   px_y;

  logic                 n_hit;
  logic [X_WIDTH-1:0]   n_xmin;
  logic [X_WIDTH-1:0]   n_xmax;
  logic [Y_WIDTH-1:0]   n_ymin;
  logic [Y_WIDTH-1:0]   n_ymax;
  logic [CNT_WIDTH-1:0] n_cnt;

  assign fe   = (pre_img.vsync == VSYNC_POL) &&
                (vsync_d != VSYNC_POL);
  assign fall = valid_d && !pre_img.valid;
  assign fg   = pre_img.valid && pre_img.data;

  // A pixel coincident with the frame edge opens the new frame at (0,0).
  assign px_x = fe ? '0 : x;
  assign px_y = fe ? '0 : y;

  always_comb begin
    n_hit  = hit;
    n_xmin = acc_xmin;
    n_xmax = acc_xmax;
    n_ymin = acc_ymin;
    n_ymax = acc_ymax;
    n_cnt  = acc_cnt;
    if (fe) begin
      n_hit  = 1'b0;
      n_xmin = '0;
      n_xmax = '0;
      n_ymin = '0;
      n_ymax = '0;
      n_cnt  = '0;
    end
    if (fg && (fe || state == ACTIVE)) begin
      if (!n_hit) begin
        n_xmin = px_x;
        n_xmax = px_x;
        n_ymin = px_y;
        n_ymax = px_y;
      end else begin
        if (px_x < n_xmin) n_xmin = px_x;
        if (px_x > n_xmax) n_xmax = px_x;
        if (px_y < n_ymin) n_ymin = px_y;
        if (px_y > n_ymax) n_ymax = px_y;
      end
      n_hit = 1'b1;
      if (n_cnt != C_MAX) n_cnt = n_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      vsync_d        <= 1'b0;
      valid_d        <= 1'b0;
      x              <= '0;
      y              <= '0;
      hit            <= 1'b0;
      acc_xmin       <= '0;
      acc_xmax       <= '0;
      acc_ymin       <= '0;
      acc_ymax       <= '0;
      acc_cnt        <= '0;
      post_img.vsync <= 1'b0;
      post_img.hsync <= 1'b0;
      post_img.valid <= 1'b0;
      post_img.data  <= 1'b0;
      bbox_valid     <= 1'b0;
      bbox_found     <= 1'b0;
      bbox_xmin      <= '0;
      bbox_xmax      <= '0;
      bbox_ymin      <= '0;
      bbox_ymax      <= '0;
      fg_count       <= '0;
    end else begin
      vsync_d        <= pre_img.vsync;
      valid_d        <= pre_img.valid;
      post_img.vsync <= pre_img.vsync;
      post_img.hsync <= pre_img.hsync;
      post_img.valid <= pre_img.valid;
      post_img.data  <= pre_img.data;

      if (fe) begin
        x <= X_WIDTH'(pre_img.valid);
        y <= '0;
      end else if (fall) begin
        x <= '0;
        if (y != Y_MAX) y <= y + 1'b1;
      end else if (pre_img.valid && x != X_MAX) begin
        x <= x + 1'b1;
      end

      hit      <= n_hit;
      acc_xmin <= n_xmin;
      acc_xmax <= n_xmax;
      acc_ymin <= n_ymin;
      acc_ymax <= n_ymax;
      acc_cnt  <= n_cnt;

      bbox_valid <= fe && state == ACTIVE;
      if (fe && state == ACTIVE) begin
        bbox_found <= hit;
        bbox_xmin  <= acc_xmin;
        bbox_xmax  <= acc_xmax;
        bbox_ymin  <= acc_ymin;
        bbox_ymax  <= acc_ymax;
        fg_count   <= acc_cnt;
      end
      if (fe) state <= ACTIVE;
    end
  end

endmodule

// File: tb/tb_bin_bbox_detect.sv
// Randomized frames checked against a pixel-array model of the bbox rules,
// on a default-size instance and a narrow instance that exercises saturation.
module tb_bin_bbox_detect;

  typedef struct {
    bit found;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
    int cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin_bbox_detect_if pre_img ();
  bin_bbox_detect_if post_a ();
  bin_bbox_detect_if post_b ();

  logic        a_valid, a_found;
  logic [10:0] a_xmin, a_xmax, a_ymin, a_ymax;
  logic [19:0] a_cnt;
  logic        b_valid, b_found;
  logic [2:0]  b_xmin, b_xmax, b_ymin, b_ymax;
  logic [4:0]  b_cnt;

  bin_bbox_detect dut_a (
    .clk(clk), .rst(rst),
    .pre_img(pre_img), .post_img(post_a),
    .bbox_valid(a_valid), .bbox_found(a_found),
    .bbox_xmin(a_xmin), .bbox_xmax(a_xmax),
    .bbox_ymin(a_ymin), .bbox_ymax(a_ymax),
    .fg_count(a_cnt)
  );

  bin_bbox_detect #(
    .X_WIDTH(3), .Y_WIDTH(3), .CNT_WIDTH(5)
  ) dut_b (
    .clk(clk), .rst(rst),
    .pre_img(pre_img), .post_img(post_b),
    .bbox_valid(b_valid), .bbox_found(b_found),
    .bbox_xmin(b_xmin), .bbox_xmax(b_xmax),
    .bbox_ymin(b_ymin), .bbox_ymax(b_ymax),
    .fg_count(b_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  bit   img [0:127][0:127];
  int   fw, fh;
  bit   open_frame = 1'b0;
  res_t qa[$];
  res_t qb[$];

  function automatic res_t model(int xw, int yw, int cw);
    res_t r;
    int   xm, ym, cm;
    xm = (1 << xw) - 1;
    ym = (1 << yw) - 1;
    cm = (1 << cw) - 1;
    r = '{0, 0, 0, 0, 0, 0};
    for (int row = 0; row < fh; row++)
      for (int col = 0; col < fw; col++)
        if (img[row][col]) begin
          int px, py;
          px = (col > xm) ? xm : col;
          py = (row > ym) ? ym : row;
          if (!r.found) begin
            r.xmin = px; r.xmax = px;
            r.ymin = py; r.ymax = py;
          end else begin
            if (px < r.xmin) r.xmin = px;
            if (px > r.xmax) r.xmax = px;
            if (py < r.ymin) r.ymin = py;
            if (py > r.ymax) r.ymax = py;
          end
          r.found = 1'b1;
          if (r.cnt < cm) r.cnt++;
        end
    return r;
  endfunction

  task automatic fill(int kind);
    int dens;
    fw = 8;
    fh = 4;
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++)
        img[r][c] = 1'b0;
    case (kind)
      1: img[2][5] = 1'b1;
      2: begin
        img[1][1] = 1'b1;
        img[1][6] = 1'b1;
        img[3][3] = 1'b1;
      end
      3: ;
      4: begin
        fw = 100;
        fh = 100;
        for (int r = 0; r < fh; r++)
          for (int c = 0; c < fw; c++)
            img[r][c] = 1'b1;
      end
      5: img[0][0] = 1'b1;
      default: begin
        fw   = $urandom_range(1, 40);
        fh   = $urandom_range(1, 20);
        dens = $urandom_range(0, 4);
        for (int r = 0; r < fh; r++)
          for (int c = 0; c < fw; c++)
            img[r][c] = ($urandom_range(0, 15) < dens);
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit vs, bit hs, bit v, bit d);
    pre_img.vsync = vs;
    pre_img.hsync = hs;
    pre_img.valid = v;
    pre_img.data  = d;
    step();
  endtask

  task automatic close_open();
    if (open_frame) begin
      qa.push_back(model(11, 11, 20));
      qb.push_back(model(3, 3, 5));
    end
  endtask

  // tight_start: vsync rises on the first pixel of row 0.
  // tight_end: the last line runs straight into the next frame edge.
  task automatic run_frame(int kind, bit tight_start, bit tight_end);
    close_open();
    fill(kind);
    if (!tight_start) begin
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
    end
    for (int r = 0; r < fh; r++) begin
      for (int c = 0; c < fw; c++)
        drive(tight_start && r == 0 && c < 2, 1, 1, img[r][c]);
      if (!(tight_end && r == fh - 1))
        repeat ($urandom_range(1, 3)) drive(0, 0, 0, 0);
    end
    open_frame = 1'b1;
  endtask

  task automatic close_edge();
    close_open();
    open_frame = 1'b0;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
  endtask

  task automatic interrupted();
    close_open();
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int c = 0; c < 8; c++) drive(0, 1, 1, 1);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    open_frame = 1'b0;
    for (int c = 0; c < 4; c++) drive(0, 1, 1, 1);
    rst = 1'b0;
    for (int c = 4; c < 8; c++) drive(0, 1, 1, 1);
    drive(0, 0, 0, 0);
    for (int c = 0; c < 8; c++) drive(0, 1, 1, 1);
    drive(0, 0, 0, 0);
  endtask

  // Cycle monitor: inputs read here are taken by the next rising edge.
  bit       started = 1'b0;
  bit       p_rst   = 1'b1;
  bit       p_pulse = 1'b0;
  bit       armed   = 1'b0;
  bit       vs_last = 1'b0;
  bit [3:0] p_in    = '0;
  res_t     la      = '{0, 0, 0, 0, 0, 0};
  res_t     lb      = '{0, 0, 0, 0, 0, 0};

  always @(negedge clk) begin
    bit fe_now;
    if (started) begin
      chk("pass_a", {post_a.vsync, post_a.hsync,
                     post_a.valid, post_a.data}, p_rst ? 4'd0 : p_in);
      chk("pass_b", {post_b.vsync, post_b.hsync,
                     post_b.valid, post_b.data}, p_rst ? 4'd0 : p_in);
      chk("pulse_a", a_valid, p_pulse);
      chk("pulse_b", b_valid, p_pulse);
      if (p_rst) begin
        la = '{0, 0, 0, 0, 0, 0};
        lb = '{0, 0, 0, 0, 0, 0};
      end else if (p_pulse) begin
        chk("frame_expected", qa.size() > 0 && qb.size() > 0, 1);
        if (qa.size() > 0) la = qa.pop_front();
        if (qb.size() > 0) lb = qb.pop_front();
      end
      chk("found_a", a_found, la.found);
      chk("xmin_a", a_xmin, la.xmin);
      chk("xmax_a", a_xmax, la.xmax);
      chk("ymin_a", a_ymin, la.ymin);
      chk("ymax_a", a_ymax, la.ymax);
      chk("count_a", a_cnt, la.cnt);
      chk("found_b", b_found, lb.found);
      chk("xmin_b", b_xmin, lb.xmin);
      chk("xmax_b", b_xmax, lb.xmax);
      chk("ymin_b", b_ymin, lb.ymin);
      chk("ymax_b", b_ymax, lb.ymax);
      chk("count_b", b_cnt, lb.cnt);
    end
    started = 1'b1;
    p_in    = {pre_img.vsync, pre_img.hsync, pre_img.valid, pre_img.data};
    p_rst   = rst;
    fe_now  = pre_img.vsync && !vs_last;
    p_pulse = !rst && fe_now && armed;
    if (rst) begin
      armed   = 1'b0;
      vs_last = 1'b0;
    end else begin
      if (fe_now) armed = 1'b1;
      vs_last = pre_img.vsync;
    end
  end

  initial begin
    bit tight;
    bit nxt;
    pre_img.vsync = 1'b0;
    pre_img.hsync = 1'b0;
    pre_img.valid = 1'b0;
    pre_img.data  = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    run_frame(1, 0, 0);
    run_frame(2, 0, 0);
    run_frame(3, 0, 0);
    run_frame(0, 0, 0);

    tight = 1'b0;
    for (int i = 0; i < 30; i++) begin
      nxt = $urandom_range(0, 1);
      run_frame(0, tight, nxt);
      tight = nxt;
    end
    run_frame(5, tight, 1);
    run_frame(5, 1, 0);

    run_frame(4, 0, 0);
    run_frame(3, 0, 0);

    interrupted();
    run_frame(5, 0, 0);
    run_frame(5, 0, 0);
    close_edge();

    chk("leftover_a", qa.size(), 0);
    chk("leftover_b", qb.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
